cacheline_adaptor: RTL and testbench

Converts whole-cacheline transfers from the victim cache's physical-memory port into fixed-length bursts on the burst memory bus, and reassembles read bursts into a cacheline. Sits directly downstream of the victim cache controller: its `vc_pmem_read` / `vc_pmem_write` / `vc_pmem_resp` handshake terminates here, and the burst bus connects to physical memory. One transaction at a time, no buffering beyond one line.

---
 rtl/mem_if_pkg.sv | 25 ++
 rtl/cacheline_adaptor.sv | 172 +++++++++++++++++
 tb/tb_cacheline_adaptor.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared memory-interface definitions for the cacheline adaptor and the cache
// controllers that sit above it.
//   LINE_W_DEF / BURST_W_DEF / ADDR_W_DEF : default bus widths
//   NBEATS / OFFSET_W                     : constants derived from the defaults
//   adaptor_state_t                       : adaptor FSM states
package mem_if_pkg;

    localparam int unsigned LINE_W_DEF  = 256;
    localparam int unsigned BURST_W_DEF = 64;
    localparam int unsigned ADDR_W_DEF  = 32;

    // Beats per line and byte-offset bits of a line address at default widths.
    localparam int unsigned NBEATS   = LINE_W_DEF / BURST_W_DEF;
    localparam int unsigned OFFSET_W = $clog2(LINE_W_DEF / 8);

    // Same encoding style as the cache controllers.
    typedef enum int unsigned {
        IDLE,
        RD,
        RD_DONE,
        WR,
        WR_DONE
    } adaptor_state_t;

endpackage : mem_if_pkg

// File: rtl/cacheline_adaptor.sv
// Cacheline <-> burst adaptor.
// Turns a whole-line read/write from the victim cache into a fixed-length burst
// on the memory bus, and reassembles read beats into a line. One transaction at
// a time; a single line register holds either the write data or the partially
// assembled read line.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   read_i, write_i        : line requests, held until resp_o
//   address_i, line_i      : line address and write data
//   line_o, resp_o         : assembled read line, one-cycle completion pulse
//   read_o, write_o        : burst requests to memory
//   address_o              : line-aligned burst address
//   burst_o                : current write beat
//   burst_i, resp_i        : read beat and per-beat strobe from memory
module cacheline_adaptor
    import mem_if_pkg::*;
#(
    parameter int unsigned LINE_W  = LINE_W_DEF,
    parameter int unsigned BURST_W = BURST_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               read_i,
    input  logic               write_i,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    output logic               resp_o,
    output logic               read_o,
    output logic               write_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic [BURST_W-1:0] burst_o,
    input  logic [BURST_W-1:0] burst_i,
    input  logic               resp_i
);

    localparam int unsigned BEATS = LINE_W / BURST_W;
    localparam int unsigned OFF_W = $clog2(LINE_W / 8);
    localparam int unsigned CNT_W = $clog2(BEATS);

    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W - OFF_W){1'b1}}, {OFF_W{1'b0}}};

    adaptor_state_t     state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [LINE_W-1:0]  buf_q,     buf_d;
    logic [LINE_W-1:0]  line_q,    line_d;
    logic [BURST_W-1:0] burst_q,   burst_d;
    logic [ADDR_W-1:0]  addr_q,    addr_d;
    logic               read_q,    read_d;
    logic               write_q,   write_d;
    logic               resp_q,    resp_d;

    logic [CNT_W-1:0]   cnt_inc;
    logic [LINE_W-1:0]  buf_merged;
    int unsigned        cur_base;
    int unsigned        nxt_base;

    // Beat addressing helpers: current slot and the slot after it.
    always_comb begin
        cnt_inc    = cnt_q + CNT_W'(1);
        cur_base   = 32'(cnt_q) * BURST_W;
        nxt_base   = 32'(cnt_inc) * BURST_W;
        buf_merged = buf_q;
        buf_merged[cur_base +: BURST_W] = burst_i;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            line_q  <= '0;
            burst_q <= '0;
            addr_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            line_q  <= line_d;
            burst_q <= burst_d;
            addr_q  <= addr_d;
            read_q  <= read_d;
            write_q <= write_d;
            resp_q  <= resp_d;
        end
    end

    // Next-state and next-output logic. Bus strobes are computed one cycle
    // ahead so that every output comes straight from a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        line_d  = line_q;
        burst_d = burst_q;
        addr_d  = addr_q;
        read_d  = 1'b0;
        write_d = 1'b0;
        resp_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Write wins when both requests are present.
                if (write_i) begin
                    addr_d  = address_i & LINE_MASK;
                    buf_d   = line_i;
                    cnt_d   = '0;
                    burst_d = line_i[BURST_W-1:0];
                    write_d = 1'b1;
                    state_d = WR;
                end else if (read_i) begin
                    addr_d  = address_i & LINE_MASK;
                    cnt_d   = '0;
                    read_d  = 1'b1;
                    state_d = RD;
                end
            end

            RD: begin
                read_d = 1'b1;
                if (resp_i) begin
                    buf_d = buf_merged;
                    cnt_d = cnt_inc;
                    if (cnt_q == LAST_BEAT) begin
                        // Publish the completed line together with resp_o.
                        line_d  = buf_merged;
                        read_d  = 1'b0;
                        resp_d  = 1'b1;
                        state_d = RD_DONE;
                    end
                end
            end

            WR: begin
                write_d = 1'b1;
                if (resp_i) begin
                    cnt_d = cnt_inc;
                    if (cnt_q == LAST_BEAT) begin
                        burst_d = '0;
                        write_d = 1'b0;
                        resp_d  = 1'b1;
                        state_d = WR_DONE;
                    end else begin
                        burst_d = buf_q[nxt_base +: BURST_W];
                    end
                end
            end

            RD_DONE, WR_DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign line_o    = line_q;
    assign resp_o    = resp_q;
    assign read_o    = read_q;
    assign write_o   = write_q;
    assign address_o = addr_q;
    assign burst_o   = burst_q;

endmodule : cacheline_adaptor

// File: tb/tb_cacheline_adaptor.sv
// Directed testbench for cacheline_adaptor with hand-computed expectations.
module tb_cacheline_adaptor;

    localparam int unsigned LW = 256;
    localparam int unsigned BW = 64;
    localparam int unsigned AW = 32;

    localparam logic [LW-1:0] LINE_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [LW-1:0] LINE_B = {64'hDDDD_0004_DDDD_0004, 64'hCCCC_0003_CCCC_0003,
                                        64'hBBBB_0002_BBBB_0002, 64'hAAAA_0001_AAAA_0001};
    localparam logic [LW-1:0] LINE_C = {64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0,
                                        64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210};

    logic          clk;
    logic          rst;
    logic          read_i;
    logic          write_i;
    logic [AW-1:0] address_i;
    logic [LW-1:0] line_i;
    logic [LW-1:0] line_o;
    logic          resp_o;
    logic          read_o;
    logic          write_o;
    logic [AW-1:0] address_o;
    logic [BW-1:0] burst_o;
    logic [BW-1:0] burst_i;
    logic          resp_i;

    int n_checks;
    int n_errors;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .read_i    (read_i),
        .write_i   (write_i),
        .address_i (address_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .address_o (address_o),
        .burst_o   (burst_o),
        .burst_i   (burst_i),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; that is the start of a new cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, ".read_o"},  LW'(read_o),  LW'(0));
        check_eq({tag, ".write_o"}, LW'(write_o), LW'(0));
        check_eq({tag, ".resp_o"},  LW'(resp_o),  LW'(0));
    endtask

    // Line read: mask bit c means memory returns a beat during cycle c.
    task automatic read_txn(input string tag, input logic [AW-1:0] addr, input logic [AW-1:0] exp_addr,
                            input logic [LW-1:0] line, input logic [31:0] mask, input int exp_resp_cyc);
        int beat     = 0;
        int resp_cyc = -1;
        int resp_cnt = 0;
        read_i    = 1'b1;
        write_i   = 1'b0;
        address_i = addr;
        resp_i    = 1'b0;
        for (int c = 1; c < 32; c++) begin
            step();
            if (resp_cyc >= 0) begin
                read_i = 1'b0;
                check_idle_outputs({tag, ".after"});
                break;
            end
            if (resp_o) begin
                resp_cnt++;
                resp_cyc = c;
                check_eq({tag, ".line_o"}, line_o, line);
                check_eq({tag, ".read_o_at_resp"}, LW'(read_o), LW'(0));
            end else begin
                check_eq({tag, ".read_o"},    LW'(read_o),    LW'(1));
                check_eq({tag, ".write_o"},   LW'(write_o),   LW'(0));
                check_eq({tag, ".address_o"}, LW'(address_o), LW'(exp_addr));
            end
            if (resp_cyc < 0 && mask[c] && beat < 4) begin
                resp_i  = 1'b1;
                burst_i = line[beat*64 +: 64];
                beat++;
            end else begin
                resp_i  = 1'b0;
                burst_i = {$urandom, $urandom};
            end
        end
        resp_i = 1'b0;
        read_i = 1'b0;
        check_eq({tag, ".resp_count"}, LW'(resp_cnt), LW'(1));
        check_eq({tag, ".resp_cycle"}, LW'(resp_cyc), LW'(exp_resp_cyc));
    endtask

    // Line write; also_read raises read_i alongside write_i.
    task automatic write_txn(input string tag, input logic [AW-1:0] addr, input logic [AW-1:0] exp_addr,
                             input logic [LW-1:0] line, input logic [31:0] mask, input int exp_resp_cyc,
                             input logic also_read);
        int beat     = 0;
        int resp_cyc = -1;
        int resp_cnt = 0;
        write_i   = 1'b1;
        read_i    = also_read;
        address_i = addr;
        line_i    = line;
        resp_i    = 1'b0;
        for (int c = 1; c < 32; c++) begin
            step();
            if (resp_cyc >= 0) begin
                write_i = 1'b0;
                read_i  = 1'b0;
                check_idle_outputs({tag, ".after"});
                break;
            end
            if (resp_o) begin
                resp_cnt++;
                resp_cyc = c;
                check_eq({tag, ".write_o_at_resp"}, LW'(write_o), LW'(0));
                check_eq({tag, ".read_o_at_resp"},  LW'(read_o),  LW'(0));
            end else begin
                check_eq({tag, ".write_o"},   LW'(write_o),   LW'(1));
                check_eq({tag, ".read_o"},    LW'(read_o),    LW'(0));
                check_eq({tag, ".address_o"}, LW'(address_o), LW'(exp_addr));
                if (beat < 4) check_eq({tag, ".burst_o"}, LW'(burst_o), LW'(line[beat*64 +: 64]));
            end
            if (resp_cyc < 0 && mask[c] && beat < 4) begin
                resp_i = 1'b1;
                beat++;
            end else begin
                resp_i = 1'b0;
            end
        end
        resp_i  = 1'b0;
        write_i = 1'b0;
        read_i  = 1'b0;
        check_eq({tag, ".resp_count"}, LW'(resp_cnt), LW'(1));
        check_eq({tag, ".resp_cycle"}, LW'(resp_cyc), LW'(exp_resp_cyc));
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        read_i    = 1'b0;
        write_i   = 1'b0;
        address_i = '0;
        line_i    = '0;
        burst_i   = '0;
        resp_i    = 1'b0;
        step();
        step();

        // Reset values
        check_idle_outputs("reset");
        check_eq("reset.line_o",    line_o,          '0);
        check_eq("reset.burst_o",   LW'(burst_o),    '0);
        check_eq("reset.address_o", LW'(address_o),  '0);
        rst = 1'b0;
        step();

        // Back-to-back read beats from cycle 1
        read_txn("rd_b2b", 32'h0000_1234, 32'h0000_1220, LINE_A, 32'b1_1110, 5);

        // Write burst with beats every cycle
        write_txn("wr_b2b", 32'h0000_ABCD, 32'h0000_ABC0, LINE_A, 32'b1_1110, 5, 1'b0);
        check_eq("wr_b2b.line_o_held", line_o, LINE_A);
        step();

        // Read with gaps: beats in cycles 3, 4, 7, 9
        read_txn("rd_gap", 32'h8000_00FF, 32'h8000_00E0, LINE_B,
                 (32'd1 << 3) | (32'd1 << 4) | (32'd1 << 7) | (32'd1 << 9), 10);
        step();

        // Read and write together: only the write runs
        write_txn("rd_wr_both", 32'h0000_2040, 32'h0000_2040, LINE_C, 32'b1_1110, 5, 1'b1);
        check_eq("rd_wr_both.line_o_held", line_o, LINE_B);
        step();
        check_idle_outputs("rd_wr_both.no_read");

        // Reset after two read beats
        read_i    = 1'b1;
        address_i = 32'h0000_0047;
        step();
        resp_i  = 1'b1;
        burst_i = 64'h5555_5555_5555_5555;
        step();
        burst_i = 64'h6666_6666_6666_6666;
        step();
        resp_i = 1'b0;
        check_eq("rst_mid.read_o_before", LW'(read_o), LW'(1));
        rst = 1'b1;
        step();
        rst    = 1'b0;
        read_i = 1'b0;
        check_idle_outputs("rst_mid");
        check_eq("rst_mid.line_o",    line_o,         '0);
        check_eq("rst_mid.burst_o",   LW'(burst_o),   '0);
        check_eq("rst_mid.address_o", LW'(address_o), '0);
        resp_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle_outputs("rst_mid.stray_resp");
        end
        resp_i = 1'b0;
        step();
        read_txn("rd_after_rst", 32'h0000_0047, 32'h0000_0040, LINE_C, 32'b1_1110, 5);
        step();

        // resp_i in IDLE with no request
        resp_i  = 1'b1;
        burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            step();
            check_idle_outputs("idle_resp");
            check_eq("idle_resp.address_o", LW'(address_o), LW'(32'h0000_0040));
            check_eq("idle_resp.line_o",    line_o,         LINE_C);
        end
        resp_i = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

endmodule : tb_cacheline_adaptor
